// File: rtl/rot_kill_aggregator_if.sv
// Bus between the monitor kill stages / CPU taps and the kill aggregator.
// master drives kill levels and trace taps; slave returns sys_reset and the violation log.
interface rot_kill_aggregator_if #(
  parameter int unsigned N_MON = 4,
  parameter int unsigned CNT_W = 8
);
  logic [N_MON-1:0] mon_reset;
  logic [15:0]      pc;
  logic [15:0]      dma_addr;
  logic             dma_en;
  logic             log_clr;
  logic             sys_reset;
  logic             viol_valid;
  logic [N_MON-1:0] viol_cause;
  logic [15:0]      viol_pc;
  logic [15:0]      viol_addr;
  logic             viol_addr_vld;
  logic [CNT_W-1:0] viol_count;

  modport master (
    output mon_reset, pc, dma_addr, dma_en, log_clr,
    input  sys_reset, viol_valid, viol_cause, viol_pc, viol_addr, viol_addr_vld, viol_count
  );

  modport slave (
    input  mon_reset, pc, dma_addr, dma_en, log_clr,
    output sys_reset, viol_valid, viol_cause, viol_pc, viol_addr, viol_addr_vld, viol_count
  );
endinterface

// File: rtl/rot_kill_aggregator.sv
// Aggregates monitor kill levels into one stretched sys_reset and keeps a
// first-violation log (cause, PC, DMA address, count) for the RoT.
module rot_kill_aggregator #(
  parameter int unsigned N_MON   = 4,
  parameter int unsigned MIN_RST = 8,
  parameter int unsigned CNT_W   = 8
) (
  input logic                  clk,
  input logic                  reset,
  rot_kill_aggregator_if.slave bus
);

  localparam int unsigned HW = (MIN_RST > 1) ? $clog2(MIN_RST) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_RST - 1);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [HW-1:0]    hcnt, hcnt_nxt;
  logic [N_MON-1:0] mon_prev, rise;
  logic             new_viol, mon_any;
  logic [15:0]      pc_d, addr_d;
  logic             en_d;

  logic             valid_nxt, vld_nxt;
  logic [N_MON-1:0] cause_nxt;
  logic [15:0]      pc_nxt, addr_nxt;
  logic [CNT_W-1:0] count_nxt;

  // Only 0->1 edges count, so the power-up kill level never looks like a violation.
  assign rise     = bus.mon_reset & ~mon_prev;
  assign new_viol = |rise;
  assign mon_any  = |bus.mon_reset;

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    case (state)
      BOOT: begin
        if (!mon_any) state_nxt = RUN;
      end
      RUN: begin
        if (new_viol) begin
          state_nxt = HOLD;
          hcnt_nxt  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (new_viol) begin
          hcnt_nxt = HOLD_LOAD;
        end else if (hcnt == '0) begin
          state_nxt = mon_any ? DRAIN : RUN;
        end else begin
          hcnt_nxt = hcnt - HW'(1);
        end
      end
      default: begin
        if (new_viol) begin
          state_nxt = HOLD;
          hcnt_nxt  = HOLD_LOAD;
        end else if (!mon_any) begin
          state_nxt = RUN;
        end
      end
    endcase
  end

  // A clear in the same cycle as a violation empties the log first, then captures.
  always_comb begin
    valid_nxt = bus.log_clr ? 1'b0 : bus.viol_valid;
    cause_nxt = bus.log_clr ? '0   : bus.viol_cause;
    pc_nxt    = bus.log_clr ? '0   : bus.viol_pc;
    addr_nxt  = bus.log_clr ? '0   : bus.viol_addr;
    vld_nxt   = bus.log_clr ? 1'b0 : bus.viol_addr_vld;
    count_nxt = bus.log_clr ? '0   : bus.viol_count;
    if (new_viol) begin
      cause_nxt = cause_nxt | rise;
      if (count_nxt != '1) count_nxt = count_nxt + CNT_W'(1);
      if (!valid_nxt) begin
        valid_nxt = 1'b1;
        pc_nxt    = pc_d;
        addr_nxt  = addr_d;
        vld_nxt   = en_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= BOOT;
      hcnt              <= '0;
      mon_prev          <= '1;
      pc_d              <= '0;
      addr_d            <= '0;
      en_d              <= 1'b0;
      bus.sys_reset     <= 1'b1;
      bus.viol_valid    <= 1'b0;
      bus.viol_cause    <= '0;
      bus.viol_pc       <= '0;
      bus.viol_addr     <= '0;
      bus.viol_addr_vld <= 1'b0;
      bus.viol_count    <= '0;
    end else begin
      state             <= state_nxt;
      hcnt              <= hcnt_nxt;
      mon_prev          <= bus.mon_reset;
      pc_d              <= bus.pc;
      addr_d            <= bus.dma_addr;
      en_d              <= bus.dma_en;
      bus.sys_reset     <= (state_nxt != RUN);
      bus.viol_valid    <= valid_nxt;
      bus.viol_cause    <= cause_nxt;
      bus.viol_pc       <= pc_nxt;
      bus.viol_addr     <= addr_nxt;
      bus.viol_addr_vld <= vld_nxt;
      bus.viol_count    <= count_nxt;
    end
  end

endmodule

// File: tb/tb_rot_kill_aggregator.sv
// Directed bench for rot_kill_aggregator: stimulus queues hand-computed expectations
// tagged with a cycle number; a negedge monitor pops and compares them.
module tb_rot_kill_aggregator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rot_kill_aggregator_if #(.N_MON(4), .CNT_W(8)) bus ();

  rot_kill_aggregator #(.N_MON(4), .MIN_RST(8), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int SEL_RST = 0, SEL_VALID = 1, SEL_CAUSE = 2, SEL_PC = 3,
                 SEL_ADDR = 4, SEL_AVLD = 5, SEL_COUNT = 6;

  typedef struct {
    int unsigned cyc;
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] act(input int sel);
    case (sel)
      SEL_RST:   return 32'(bus.sys_reset);
      SEL_VALID: return 32'(bus.viol_valid);
      SEL_CAUSE: return 32'(bus.viol_cause);
      SEL_PC:    return 32'(bus.viol_pc);
      SEL_ADDR:  return 32'(bus.viol_addr);
      SEL_AVLD:  return 32'(bus.viol_addr_vld);
      default:   return 32'(bus.viol_count);
    endcase
  endfunction

  task automatic expect_at(input int unsigned c, input string name, input int sel,
                           input logic [31:0] v);
    exp_t e;
    e.cyc = c; e.name = name; e.sel = sel; e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_log(input int unsigned c, input string tag, input logic valid,
                            input logic [3:0] cause, input logic [15:0] pc,
                            input logic [15:0] addr, input logic avld,
                            input logic [7:0] count);
    expect_at(c, {tag, "_valid"}, SEL_VALID, 32'(valid));
    expect_at(c, {tag, "_cause"}, SEL_CAUSE, 32'(cause));
    expect_at(c, {tag, "_pc"},    SEL_PC,    32'(pc));
    expect_at(c, {tag, "_addr"},  SEL_ADDR,  32'(addr));
    expect_at(c, {tag, "_avld"},  SEL_AVLD,  32'(avld));
    expect_at(c, {tag, "_count"}, SEL_COUNT, 32'(count));
  endtask

  always @(negedge clk) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc < cyc || act(sb[i].sel) !== sb[i].val) begin
          errors++;
          $display("FAIL %s @cycle %0d: got %0h expected %0h", sb[i].name, sb[i].cyc,
                   act(sb[i].sel), sb[i].val);
        end
        sb.delete(i);
      end
    end
    if (done) begin
      foreach (sb[i]) begin
        checks++;
        errors++;
        $display("FAIL %s @cycle %0d: never compared, expected %0h", sb[i].name, sb[i].cyc,
                 sb[i].val);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) tick();
  endtask

  int unsigned c0, d, k, p, p2, t, x;

  initial begin
    reset         = 1'b1;
    bus.mon_reset = 4'hF;
    bus.pc        = '0;
    bus.dma_addr  = '0;
    bus.dma_en    = 1'b0;
    bus.log_clr   = 1'b0;

    // reset state
    expect_at(2, "rst_sys_reset", SEL_RST, 32'd1);
    expect_log(2, "rst", 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 8'h0);
    repeat (3) tick();

    // test 1: boot-time kill level held 5 cycles, then dropped
    reset = 1'b0;
    c0 = cyc;
    expect_at(c0 + 2, "t1_boot_rst", SEL_RST, 32'd1);
    repeat (5) tick();
    d = cyc;
    bus.mon_reset = 4'h0;
    expect_at(d,     "t1_drop_rst",  SEL_RST,   32'd1);
    expect_at(d + 1, "t1_run_rst",   SEL_RST,   32'd0);
    expect_at(d + 1, "t1_no_valid",  SEL_VALID, 32'd0);
    expect_at(d + 1, "t1_no_count",  SEL_COUNT, 32'd0);

    // test 2: first violation captures the previous cycle's PC/DMA address
    wait_until(d + 3);
    k = cyc;
    bus.pc = 16'hE010; bus.dma_addr = 16'h0B20; bus.dma_en = 1'b1;
    tick();
    bus.mon_reset = 4'h1;
    bus.pc = 16'h1234; bus.dma_addr = 16'h5678; bus.dma_en = 1'b0;
    expect_at(k + 1, "t2_pre_rst", SEL_RST, 32'd0);
    expect_at(k + 2, "t2_rst",     SEL_RST, 32'd1);
    expect_log(k + 2, "t2", 1'b1, 4'h1, 16'hE010, 16'h0B20, 1'b1, 8'd1);
    tick();
    bus.mon_reset = 4'h0;

    // test 4: second violation at hcnt==3 reloads hold, log keeps first capture
    wait_until(k + 5);
    bus.pc = 16'hBEEF; bus.dma_addr = 16'hCAFE; bus.dma_en = 1'b1;
    tick();
    bus.mon_reset = 4'h4;
    expect_log(k + 7, "t4", 1'b1, 4'h5, 16'hE010, 16'h0B20, 1'b1, 8'd2);
    expect_at(k + 7,  "t4_rst_start", SEL_RST, 32'd1);
    expect_at(k + 14, "t4_rst_last",  SEL_RST, 32'd1);
    expect_at(k + 15, "t4_rst_end",   SEL_RST, 32'd0);
    tick();
    bus.mon_reset = 4'h0;

    // test 3a: one-cycle pulse gives exactly MIN_RST cycles of sys_reset
    wait_until(k + 20);
    p = cyc;
    bus.mon_reset = 4'h2;
    expect_at(p, "t3p_rst_pre", SEL_RST, 32'd0);
    for (int unsigned i = 1; i <= 8; i++) expect_at(p + i, "t3p_rst_hi", SEL_RST, 32'd1);
    expect_at(p + 9, "t3p_rst_end", SEL_RST, 32'd0);
    expect_at(p + 1, "t3p_cause", SEL_CAUSE, 32'h7);
    expect_at(p + 1, "t3p_count", SEL_COUNT, 32'd3);
    tick();
    bus.mon_reset = 4'h0;

    // test 3b: level held 20 cycles stretches sys_reset to the cycle after release
    wait_until(p + 12);
    p2 = cyc;
    bus.mon_reset = 4'h2;
    expect_at(p2 + 1,  "t3l_rst_start", SEL_RST,   32'd1);
    expect_at(p2 + 10, "t3l_rst_drain", SEL_RST,   32'd1);
    expect_at(p2 + 20, "t3l_rst_last",  SEL_RST,   32'd1);
    expect_at(p2 + 21, "t3l_rst_end",   SEL_RST,   32'd0);
    expect_at(p2 + 1,  "t3l_count",     SEL_COUNT, 32'd4);
    wait_until(p2 + 20);
    bus.mon_reset = 4'h0;
    wait_until(p2 + 25);

    // test 5: counter saturation, then clear coinciding with a new violation
    for (int unsigned i = 0; i < 300; i++) begin
      bus.mon_reset = 4'h1;
      tick();
      bus.mon_reset = 4'h0;
      tick();
    end
    t = cyc;
    expect_at(t, "t5_sat_count", SEL_COUNT, 32'hFF);
    expect_at(t, "t5_sat_cause", SEL_CAUSE, 32'h7);
    expect_at(t, "t5_sat_pc",    SEL_PC,    32'hE010);
    bus.pc = 16'hA5A5; bus.dma_addr = 16'h1111; bus.dma_en = 1'b0;
    tick();
    x = cyc;
    bus.log_clr = 1'b1;
    bus.mon_reset = 4'h8;
    bus.pc = 16'h0000; bus.dma_addr = 16'h0000; bus.dma_en = 1'b1;
    expect_log(x + 1, "t5_clr", 1'b1, 4'h8, 16'hA5A5, 16'h1111, 1'b0, 8'd1);
    expect_at(x + 1, "t5_clr_rst", SEL_RST, 32'd1);
    tick();
    bus.log_clr = 1'b0;
    bus.mon_reset = 4'h0;

    // test 6: reset during HOLD returns to BOOT with an empty log
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_at(x + 3, "t6_boot_rst", SEL_RST, 32'd1);
    expect_log(x + 3, "t6", 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 8'd0);
    expect_at(x + 4, "t6_run_rst", SEL_RST, 32'd0);
    wait_until(x + 8);
    done = 1'b1;
  end

endmodule
